// File: rtl/alarm_ring_ctrl_if.sv
// alarm_ring_ctrl_if: groups the timekeeper / alarm-set inputs and the
// LED / buzzer / status outputs of alarm_ring_ctrl into one bundle.
// master: the environment driving the controller (set stage, timekeeper, buttons).
// slave : the alarm ring controller itself.
interface alarm_ring_ctrl_if;
  logic        tick_1hz;
  logic [15:0] cur_time;
  logic [15:0] alarm;
  logic        finish_set;
  logic        alarm_en;
  logic        push_c;
  logic        push_d;
  logic        ringing;
  logic        buzzer;
  logic [15:0] led;
  logic        armed;
  logic [7:0]  sec_left;

  modport master (
    output tick_1hz, cur_time, alarm, finish_set, alarm_en, push_c, push_d,
    input  ringing, buzzer, led, armed, sec_left
  );

  modport slave (
    input  tick_1hz, cur_time, alarm, finish_set, alarm_en, push_c, push_d,
    output ringing, buzzer, led, armed, sec_left
  );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: latches the BCD mm:ss alarm from the set stage, compares it
// with the running clock, and rings (blinking LEDs plus buzzer tone) with
// stop, auto-timeout and optional snooze.
// Optional feature macro: ALARM_SNOOZE_EN (snooze state and push_d handling).
// Without it, push_d is ignored and ringing ends only by stop, timeout or disarm.
module alarm_ring_ctrl #(
  parameter int RING_SECS   = 30,
  parameter int SNOOZE_SECS = 10,
  parameter int MAX_SNOOZE  = 3,
  parameter int TONE_DIV    = 50000
) (
  input  logic             clk,
  input  logic             reset,
  alarm_ring_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_RINGING = 2'd2;
`ifdef ALARM_SNOOZE_EN
  localparam logic [1:0] ST_SNOOZE  = 2'd3;
`endif

  localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  localparam logic [7:0]        RING_SECS_C = 8'(RING_SECS);
  localparam logic [TONE_W-1:0] TONE_LAST_C = TONE_W'(TONE_DIV - 1);
`ifdef ALARM_SNOOZE_EN
  localparam logic [7:0] SNOOZE_SECS_C = 8'(SNOOZE_SECS);
  localparam logic [7:0] MAX_SNOOZE_C  = 8'(MAX_SNOOZE);
`endif

  // Second counter never wraps below zero.
  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    if (v == 8'd0) begin
      sat_dec = 8'd0;
    end else begin
      sat_dec = v - 8'd1;
    end
  endfunction

  logic [1:0]        state_r;
  logic [15:0]       alarm_q_r;
  logic              finish_set_d_r;
  logic              match_d_r;
  logic [7:0]        sec_cnt_r;
  logic [TONE_W-1:0] tone_cnt_r;
  logic              buzzer_r;
  logic [15:0]       led_r;
  logic              ringing_r;
  logic              armed_r;
`ifdef ALARM_SNOOZE_EN
  logic [7:0]        snooze_cnt_r;
  logic [7:0]        snooze_cnt_s;
`endif

  logic [1:0]        state_s;
  logic [7:0]        sec_cnt_s;
  logic [7:0]        dec_s;
  logic [TONE_W-1:0] tone_cnt_s;
  logic              buzzer_s;
  logic [15:0]       led_s;
  logic              enter_ring_s;
  logic              armed_s;
  logic              match_s;
  logic              hit_s;
  logic              capture_s;

  // Match detection: a hit is the first cycle of equality, so one match rings once.
  always_comb begin
    match_s   = (bus.cur_time == alarm_q_r);
    hit_s     = match_s & ~match_d_r;
    capture_s = bus.finish_set & ~finish_set_d_r;
    dec_s     = sat_dec(sec_cnt_r);
  end

  // Next-state, counter and output computation.
  always_comb begin
    state_s      = state_r;
    sec_cnt_s    = sec_cnt_r;
    led_s        = led_r;
    tone_cnt_s   = tone_cnt_r;
    buzzer_s     = buzzer_r;
    enter_ring_s = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snooze_cnt_s = snooze_cnt_r;
`endif

    if (!bus.alarm_en) begin
      // Disarm dominates everything in every state.
      state_s   = ST_IDLE;
      sec_cnt_s = 8'd0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_s = 8'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.finish_set) begin
            state_s = ST_ARMED;
          end else begin
            state_s = ST_IDLE;
          end
          sec_cnt_s = 8'd0;
        end
        ST_ARMED: begin
          if (hit_s) begin
            state_s      = ST_RINGING;
            sec_cnt_s    = RING_SECS_C;
            enter_ring_s = 1'b1;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_s = 8'd0;
`endif
          end else begin
            state_s   = ST_ARMED;
            sec_cnt_s = 8'd0;
          end
        end
        ST_RINGING: begin
          if (bus.push_c) begin
            state_s   = ST_ARMED;
            sec_cnt_s = 8'd0;
`ifdef ALARM_SNOOZE_EN
          end else if (bus.push_d) begin
            if (snooze_cnt_r < MAX_SNOOZE_C) begin
              state_s      = ST_SNOOZE;
              sec_cnt_s    = SNOOZE_SECS_C;
              snooze_cnt_s = snooze_cnt_r + 8'd1;
            end else begin
              // Snooze budget spent: the request acts as a stop.
              state_s   = ST_ARMED;
              sec_cnt_s = 8'd0;
            end
`endif
          end else if (bus.tick_1hz) begin
            if (dec_s == 8'd0) begin
              state_s   = ST_ARMED;
              sec_cnt_s = 8'd0;
            end else begin
              state_s   = ST_RINGING;
              sec_cnt_s = dec_s;
            end
          end else begin
            state_s = ST_RINGING;
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (bus.push_c) begin
            state_s   = ST_ARMED;
            sec_cnt_s = 8'd0;
          end else if (bus.tick_1hz) begin
            if (dec_s == 8'd0) begin
              state_s      = ST_RINGING;
              sec_cnt_s    = RING_SECS_C;
              enter_ring_s = 1'b1;
            end else begin
              state_s   = ST_SNOOZE;
              sec_cnt_s = dec_s;
            end
          end else begin
            state_s = ST_SNOOZE;
          end
        end
`endif
        default: begin
          state_s   = ST_IDLE;
          sec_cnt_s = 8'd0;
        end
      endcase
    end

    // LED blink and tone generation follow the next state.
    if (enter_ring_s) begin
      led_s      = 16'hFFFF;
      tone_cnt_s = {TONE_W{1'b0}};
      buzzer_s   = 1'b0;
    end else if (state_s == ST_RINGING) begin
      if (bus.tick_1hz) begin
        led_s = ~led_r;
      end else begin
        led_s = led_r;
      end
      if (tone_cnt_r == TONE_LAST_C) begin
        tone_cnt_s = {TONE_W{1'b0}};
        buzzer_s   = ~buzzer_r;
      end else begin
        tone_cnt_s = tone_cnt_r + {{(TONE_W-1){1'b0}}, 1'b1};
        buzzer_s   = buzzer_r;
      end
    end else begin
      led_s      = 16'h0000;
      tone_cnt_s = {TONE_W{1'b0}};
      buzzer_s   = 1'b0;
    end

`ifdef ALARM_SNOOZE_EN
    armed_s = (state_s == ST_ARMED) || (state_s == ST_SNOOZE);
`else
    armed_s = (state_s == ST_ARMED);
`endif
  end

  // Alarm capture and match history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_q_r      <= 16'h0000;
      finish_set_d_r <= 1'b0;
      match_d_r      <= 1'b0;
    end else begin
      finish_set_d_r <= bus.finish_set;
      match_d_r      <= match_s;
      if (capture_s) begin
        alarm_q_r <= bus.alarm;
      end else begin
        alarm_q_r <= alarm_q_r;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      sec_cnt_r  <= 8'd0;
      tone_cnt_r <= {TONE_W{1'b0}};
      buzzer_r   <= 1'b0;
      led_r      <= 16'h0000;
      ringing_r  <= 1'b0;
      armed_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      sec_cnt_r  <= sec_cnt_s;
      tone_cnt_r <= tone_cnt_s;
      buzzer_r   <= buzzer_s;
      led_r      <= led_s;
      ringing_r  <= (state_s == ST_RINGING);
      armed_r    <= armed_s;
    end
  end

`ifdef ALARM_SNOOZE_EN
  // Snooze usage within the current alarm event.
  always_ff @(posedge clk) begin
    if (reset) begin
      snooze_cnt_r <= 8'd0;
    end else begin
      snooze_cnt_r <= snooze_cnt_s;
    end
  end
`endif

  assign bus.ringing  = ringing_r;
  assign bus.buzzer   = buzzer_r;
  assign bus.led      = led_r;
  assign bus.armed    = armed_r;
  assign bus.sec_left = sec_cnt_r;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed testbench for alarm_ring_ctrl (TONE_DIV=4, other parameters default).
// Snooze scenarios are exercised when ALARM_SNOOZE_EN is defined; otherwise
// the bench checks that push_d is ignored.
module tb_alarm_ring_ctrl;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  alarm_ring_ctrl_if ifc ();

  alarm_ring_ctrl #(
    .RING_SECS  (30),
    .SNOOZE_SECS(10),
    .MAX_SNOOZE (3),
    .TONE_DIV   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle tick pulse followed by one quiet cycle.
  task automatic tick();
    ifc.tick_1hz = 1'b1;
    cyc();
    ifc.tick_1hz = 1'b0;
    cyc();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step time away from and back onto the alarm value to get a fresh match.
  task automatic ring_again(input string tag);
    ifc.cur_time = 16'h0106;
    cyc();
    ifc.cur_time = 16'h0105;
    cyc();
    chk(tag, {31'd0, ifc.ringing}, 32'd1);
    chk({tag, "_sec"}, {24'd0, ifc.sec_left}, 32'd30);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    ifc.tick_1hz   = 1'b0;
    ifc.cur_time   = 16'h0000;
    ifc.alarm      = 16'h0000;
    ifc.finish_set = 1'b0;
    ifc.alarm_en   = 1'b0;
    ifc.push_c     = 1'b0;
    ifc.push_d     = 1'b0;
    cyc();
    cyc();
    chk("rst_ringing", {31'd0, ifc.ringing}, 32'd0);
    chk("rst_buzzer",  {31'd0, ifc.buzzer},  32'd0);
    chk("rst_led",     {16'd0, ifc.led},     32'd0);
    chk("rst_armed",   {31'd0, ifc.armed},   32'd0);
    chk("rst_sec",     {24'd0, ifc.sec_left}, 32'd0);
    reset = 1'b0;

    // Arm with alarm 01:05.
    ifc.alarm      = 16'h0105;
    ifc.cur_time   = 16'h0104;
    ifc.alarm_en   = 1'b1;
    ifc.finish_set = 1'b1;
    cyc();
    chk("arm_armed",   {31'd0, ifc.armed},   32'd1);
    chk("arm_ringing", {31'd0, ifc.ringing}, 32'd0);
    cyc();
    chk("no_early_ring", {31'd0, ifc.ringing}, 32'd0);

    // Match -> ring one cycle later.
    ifc.cur_time = 16'h0105;
    cyc();
    chk("hit_ringing", {31'd0, ifc.ringing}, 32'd1);
    chk("hit_led",     {16'd0, ifc.led},     32'h0000FFFF);
    chk("hit_sec",     {24'd0, ifc.sec_left}, 32'd30);
    chk("hit_armed",   {31'd0, ifc.armed},   32'd0);
    chk("tone_0",      {31'd0, ifc.buzzer},  32'd0);

    // Buzzer: 4 cycles low, 4 cycles high, then low (period 8).
    repeat (3) cyc();
    chk("tone_3", {31'd0, ifc.buzzer}, 32'd0);
    cyc();
    chk("tone_4", {31'd0, ifc.buzzer}, 32'd1);
    repeat (3) cyc();
    chk("tone_7", {31'd0, ifc.buzzer}, 32'd1);
    cyc();
    chk("tone_8", {31'd0, ifc.buzzer}, 32'd0);

    // Countdown with LED blink.
    tick();
    chk("tick1_sec", {24'd0, ifc.sec_left}, 32'd29);
    chk("tick1_led", {16'd0, ifc.led},      32'h00000000);
    tick();
    chk("tick2_sec", {24'd0, ifc.sec_left}, 32'd28);
    chk("tick2_led", {16'd0, ifc.led},      32'h0000FFFF);
    repeat (27) tick();
    chk("tick29_sec",  {24'd0, ifc.sec_left}, 32'd1);
    chk("tick29_led",  {16'd0, ifc.led},      32'h00000000);
    chk("tick29_ring", {31'd0, ifc.ringing},  32'd1);
    tick();
    chk("timeout_ring",  {31'd0, ifc.ringing},  32'd0);
    chk("timeout_armed", {31'd0, ifc.armed},    32'd1);
    chk("timeout_sec",   {24'd0, ifc.sec_left}, 32'd0);
    chk("timeout_buzz",  {31'd0, ifc.buzzer},   32'd0);
    repeat (5) cyc();
    tick();
    chk("hold_no_rering", {31'd0, ifc.ringing}, 32'd0);

    // Stop at sec_left=17.
    ring_again("ring2");
    repeat (13) tick();
    chk("pre_stop_sec", {24'd0, ifc.sec_left}, 32'd17);
    ifc.push_c = 1'b1;
    cyc();
    ifc.push_c = 1'b0;
    chk("stop_ring",  {31'd0, ifc.ringing},  32'd0);
    chk("stop_buzz",  {31'd0, ifc.buzzer},   32'd0);
    chk("stop_armed", {31'd0, ifc.armed},    32'd1);
    chk("stop_sec",   {24'd0, ifc.sec_left}, 32'd0);

    ring_again("ring3");
`ifdef ALARM_SNOOZE_EN
    for (int k = 0; k < 3; k++) begin
      ifc.push_d = 1'b1;
      cyc();
      ifc.push_d = 1'b0;
      chk("snz_ring",  {31'd0, ifc.ringing},  32'd0);
      chk("snz_sec",   {24'd0, ifc.sec_left}, 32'd10);
      chk("snz_armed", {31'd0, ifc.armed},    32'd1);
      repeat (9) tick();
      chk("snz_still", {31'd0, ifc.ringing}, 32'd0);
      tick();
      chk("rering",     {31'd0, ifc.ringing},  32'd1);
      chk("rering_sec", {24'd0, ifc.sec_left}, 32'd30);
      chk("rering_led", {16'd0, ifc.led},      32'h0000FFFF);
    end
    ifc.push_d = 1'b1;
    cyc();
    ifc.push_d = 1'b0;
    chk("snz4_ring",  {31'd0, ifc.ringing}, 32'd0);
    chk("snz4_armed", {31'd0, ifc.armed},   32'd1);
    repeat (12) tick();
    chk("snz4_no_rering", {31'd0, ifc.ringing}, 32'd0);
`else
    ifc.push_d = 1'b1;
    cyc();
    ifc.push_d = 1'b0;
    chk("pd_ignored_ring", {31'd0, ifc.ringing},  32'd1);
    chk("pd_ignored_sec",  {24'd0, ifc.sec_left}, 32'd30);
    tick();
    chk("pd_count_on", {24'd0, ifc.sec_left}, 32'd29);
    ifc.push_c = 1'b1;
    cyc();
    ifc.push_c = 1'b0;
    chk("pd_stop", {31'd0, ifc.ringing}, 32'd0);
`endif

    // Stop and snooze together: stop wins.
    ring_again("ring4");
    ifc.push_c = 1'b1;
    ifc.push_d = 1'b1;
    cyc();
    ifc.push_c = 1'b0;
    ifc.push_d = 1'b0;
    chk("cd_ring",  {31'd0, ifc.ringing},  32'd0);
    chk("cd_armed", {31'd0, ifc.armed},    32'd1);
    chk("cd_sec",   {24'd0, ifc.sec_left}, 32'd0);

    // Disarm while ringing.
    ring_again("ring5");
    ifc.alarm_en = 1'b0;
    cyc();
    chk("dis_ring",  {31'd0, ifc.ringing},  32'd0);
    chk("dis_armed", {31'd0, ifc.armed},    32'd0);
    chk("dis_led",   {16'd0, ifc.led},      32'd0);
    chk("dis_sec",   {24'd0, ifc.sec_left}, 32'd0);
    ifc.alarm_en = 1'b1;
    cyc();
    chk("rearm", {31'd0, ifc.armed}, 32'd1);

    // Alarm value is not re-captured while finish_set stays high.
    ifc.alarm    = 16'h0200;
    ifc.cur_time = 16'h0200;
    cyc();
    cyc();
    chk("no_recapture", {31'd0, ifc.ringing}, 32'd0);
    ifc.alarm = 16'h0105;

    // Reset held two cycles while ringing.
    ring_again("ring6");
    reset = 1'b1;
    cyc();
    cyc();
    chk("rr_ring",  {31'd0, ifc.ringing},  32'd0);
    chk("rr_buzz",  {31'd0, ifc.buzzer},   32'd0);
    chk("rr_led",   {16'd0, ifc.led},      32'd0);
    chk("rr_armed", {31'd0, ifc.armed},    32'd0);
    chk("rr_sec",   {24'd0, ifc.sec_left}, 32'd0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
